div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller for the RV32M DIV/DIVU/REM/REMU instructions in the EX stage of the RV32IM pipeline. It accepts a start pulse from EX, sequences a radix-2 restoring divide one quotient bit per cycle, and holds the pipeline stalled until the result is ready. It handles the RISC-V divide-by-zero and signed-overflow corner cases early, without iterating.

Parameters:
XLEN, 32, operand/result width in bits
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
CLK  input  1  pipeline clock, rising-edge
RESET  input  1  asynchronous active-high reset
START  input  1  one-cycle request: EX holds a divide op; sampled only in IDLE
FUNCT3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled with START
OPERAND_A  input  XLEN  dividend, sampled with START
OPERAND_B  input  XLEN  divisor, sampled with START
FLUSH  input  1  kill in-flight op (branch mispredict/exception)
STALL  output  1  freeze IF/ID/EX pipeline registers
BUSY  output  1  sequencer not in IDLE
RESULT  output  XLEN  quotient or remainder per latched FUNCT3
RESULT_VALID  output  1  one-cycle pulse, RESULT valid this cycle

Behaviour:
- Reset (async): state IDLE, counter 0, RESULT 0, RESULT_VALID 0, BUSY 0; STALL=0 because START is gated by reset.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: on START & !FLUSH, latch FUNCT3, signed = !FUNCT3[0], sign bits, and operand magnitudes (negate negatives when signed).
- IDLE special cases:
  - If OPERAND_B==0, go to DONE with quotient=all ones and remainder=OPERAND_A.
  - Else if signed & A==0x80000000 & B==0xFFFFFFFF, go to DONE with quotient=0x80000000 and remainder=0.
  - Otherwise go to CALC with counter=XLEN-1, partial remainder=0, quotient register=|A|.
- CALC, each cycle:
  - Form trial = {rem[XLEN-2:0], q[XLEN-1]} - |B| on XLEN+1 bits.
  - If non-negative, rem <= trial and shift 1 into q; else rem <= shifted value and shift 0 into q.
  - Decrement the counter; after the iteration at count 0, go to FIXUP. CALC is exactly XLEN cycles.
- FIXUP:
  - Signed, sign(A)!=sign(B): negate quotient.
  - Signed, A negative: negate remainder.
  - Load RESULT with quotient (FUNCT3[1]=0) or remainder (FUNCT3[1]=1); go to DONE.
  - Special cases load RESULT on the IDLE->DONE transition.
- DONE: RESULT_VALID=1 for exactly this cycle; return to IDLE.
- STALL is combinational: STALL = (START & state==IDLE & !FLUSH) | state==CALC | state==FIXUP.
  - STALL is low in DONE so EX advances and captures RESULT.
  - The START cycle stalls, so the divide op stays in EX.
- BUSY = state!=IDLE.
- Latency, START cycle = cycle 0:
  - Special case: RESULT_VALID in cycle 1; 1 stall cycle.
  - Normal: CALC cycles 1..32, FIXUP cycle 33, RESULT_VALID cycle 34; 34 stall cycles.
- START while BUSY is ignored; the pipeline cannot issue one while stalled.
- FLUSH:
  - In any state, next edge goes to IDLE. No RESULT_VALID; RESULT keeps its old value.
  - FLUSH beats START in the same cycle.
  - FLUSH in DONE cancels nothing: the pulse already occurred.
- RESULT holds its value between completions. It changes only on FIXUP->DONE or special IDLE->DONE.
- Reset mid-operation: immediate return to reset values; no RESULT_VALID.
- Arithmetic is unsigned on magnitudes. Negation is two's complement on XLEN bits; -0x80000000 wraps to itself, which is correct for DIV/REM.

Decomposition:
- Shared package (cpu-wide defs):
  - FUNCT3 encodings DIV/DIVU/REM/REMU
  - opcode OP (0110011) and funct7 MULDIV (0000001), for the decoder that drives START
  - state encoding IDLE=2'd0, CALC=2'd1, FIXUP=2'd2, DONE=2'd3
  - constants INT_MIN=0x80000000 and ALL_ONES
- One natural sub-module: div_step. It is combinational and performs one restoring iteration (shift, trial subtract, select), instantiated once inside div_sequencer.

Test Plan:
- DIV 7 / -2 (0x00000007, 0xFFFFFFFE) -> RESULT 0xFFFFFFFD, RESULT_VALID at cycle 34, STALL high cycles 0-33, low cycle 34; REM same operands -> 0x00000001.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF; REMU 100 / 7 -> 0x00000002; REM -7 / 2 -> 0xFFFFFFFF (sign of dividend).
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 0x00000005, RESULT_VALID at cycle 1, STALL high only in cycle 0.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0x00000000, RESULT_VALID at cycle 1.
- DIV 100/3 then FLUSH at cycle 10 -> IDLE at cycle 11, STALL low, no RESULT_VALID, RESULT unchanged. Then START DIVU 9/3 -> 0x00000003 at cycle 34 after its start.
- Assert RESET at cycle 15 of a DIV -> BUSY/RESULT/RESULT_VALID 0 immediately. START with FLUSH both high -> stays IDLE, STALL 0.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : div_sequencer_pkg
// Purpose  : Shared CPU-wide definitions for the RV32M divide sequencer:
//            datapath widths, M-extension decode constants, FSM encoding,
//            and a two's-complement helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // funct3 encodings of the divide/remainder group
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Decoder-side constants that qualify a divide op before START is raised
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Two's complement on XLEN bits; INT_MIN maps to itself.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : div_sequencer_if
// Purpose  : EX-stage <-> divide sequencer handshake bundle.
// Ports    : master (EX stage) drives start/funct3/operand_a/operand_b/flush,
//            receives stall/busy/result/result_valid.
//            slave (sequencer) is the mirror image.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output start, funct3, operand_a, operand_b, flush,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, flush,
    output stall, busy, result, result_valid
  );

endinterface

`default_nettype wire

// File: rtl/div_sequencer_step.sv
//------------------------------------------------------------------------------
// Module   : div_step
// Purpose  : One combinational radix-2 restoring divide iteration.
// Ports    : rem_in  - partial remainder, low XLEN-1 bits (its MSB is always
//                      zero before a shift, so it is not needed)
//            quo_in  - quotient/dividend shift register
//            divisor - divisor magnitude
//            rem_out - next partial remainder
//            quo_out - next quotient register (new quotient bit in LSB)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_sequencer_pkg::*;
(
  input  logic [XLEN-2:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN-1:0] shifted;
  logic [XLEN:0]   trial;

  // Next dividend bit enters the remainder from the top of the quotient reg.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign trial   = {1'b0, shifted} - {1'b0, divisor};

  // trial[XLEN] set means the subtraction went negative: restore.
  assign rem_out = trial[XLEN] ? shifted : trial[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~trial[XLEN]};

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
//------------------------------------------------------------------------------
// Module   : div_sequencer
// Purpose  : Multi-cycle RV32M DIV/DIVU/REM/REMU controller. Runs a restoring
//            divide on operand magnitudes, one quotient bit per cycle, then
//            applies sign fix-up. Divide-by-zero and INT_MIN/-1 complete
//            immediately. Stalls the pipeline until the result is ready.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-high reset
//            bus - div_sequencer_if.slave (start/funct3/operands/flush in,
//                  stall/busy/result/result_valid out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  div_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0] rem_q,     rem_d;
  logic [XLEN-1:0] quo_q,     quo_d;
  logic [XLEN-1:0] dvs_q,     dvs_d;
  logic [XLEN-1:0] result_q,  result_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;

  assign is_signed = ~bus.funct3[0];
  assign a_neg     = is_signed & bus.operand_a[XLEN-1];
  assign b_neg     = is_signed & bus.operand_b[XLEN-1];
  assign fix_quo   = neg_quo_q ? negate(quo_q) : quo_q;
  assign fix_rem   = neg_rem_q ? negate(rem_q) : rem_q;

  div_step u_step (
    .rem_in  (rem_q[XLEN-2:0]),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          rem_sel_d = bus.funct3[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (bus.operand_b == '0) begin
            result_d = bus.funct3[1] ? bus.operand_a : ALL_ONES;
            state_d  = ST_DONE;
          end else if (is_signed && bus.operand_a == INT_MIN &&
                       bus.operand_b == ALL_ONES) begin
            result_d = bus.funct3[1] ? '0 : INT_MIN;
            state_d  = ST_DONE;
          end else begin
            cnt_d   = CNT_LAST;
            rem_d   = '0;
            quo_d   = a_neg ? negate(bus.operand_a) : bus.operand_a;
            dvs_d   = b_neg ? negate(bus.operand_b) : bus.operand_b;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FIXUP: begin
        result_d = rem_sel_q ? fix_rem : fix_quo;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the op without touching the architectural result.
    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // Outputs
  always_comb begin
    bus.stall        = (bus.start && state_q == ST_IDLE && !bus.flush) ||
                       state_q == ST_CALC || state_q == ST_FIXUP;
    bus.busy         = (state_q != ST_IDLE);
    bus.result_valid = (state_q == ST_DONE);
    bus.result       = result_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_div_sequencer
// Purpose  : Self-checking bench for div_sequencer: directed RISC-V corner
//            cases, flush/reset behaviour, and random ops against an
//            arithmetic reference model.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  div_sequencer_if bus_if ();

  div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit sgn;
    bit want_rem;
    sgn      = (f3 == F3_DIV) || (f3 == F3_REM);
    want_rem = (f3 == F3_REM) || (f3 == F3_REMU);
    sa = a;
    sb = b;
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return want_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return want_rem ? 32'(sa % sb) : 32'(sa / sb);
    return want_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (f3 == F3_DIV) || (f3 == F3_REM);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int exp_lat;
    int got_lat;
    int stalls;
    bit done;
    exp     = ref_result(f3, a, b);
    exp_lat = ref_latency(f3, a, b);
    got_lat = 0;
    stalls  = 0;
    done    = 1'b0;
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.funct3    = f3;
    bus_if.operand_a = a;
    bus_if.operand_b = b;
    #1;
    chk({tag, "_stall_c0"}, 32'(bus_if.stall), 32'd1);
    stalls = 1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus_if.result_valid) begin
        done    = 1'b1;
        got_lat = cyc;
        chk({tag, "_result"}, bus_if.result, exp);
        chk({tag, "_stall_done"}, 32'(bus_if.stall), 32'd0);
      end else if (bus_if.stall) begin
        stalls++;
      end
    end
    chk({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(bus_if.result_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_hold"}, bus_if.result, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] a, b;
    logic [2:0]  f3;
    bit          seen_rv;
    n_total = 0;
    n_bad   = 0;
    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.funct3    = 3'b000;
    bus_if.operand_a = '0;
    bus_if.operand_b = '0;
    bus_if.flush     = 1'b0;
    #1;
    chk("rst_busy",   32'(bus_if.busy), 32'd0);
    chk("rst_result", bus_if.result, 32'd0);
    chk("rst_rv",     32'(bus_if.result_valid), 32'd0);
    chk("rst_stall",  32'(bus_if.stall), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    run_op("div_7_m2",    F3_DIV,  32'h0000_0007, 32'hFFFF_FFFE);
    run_op("rem_7_m2",    F3_REM,  32'h0000_0007, 32'hFFFF_FFFE);
    run_op("divu_max_1",  F3_DIVU, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("remu_100_7",  F3_REMU, 32'd100,       32'd7);
    run_op("rem_m7_2",    F3_REM,  32'hFFFF_FFF9, 32'd2);
    run_op("divu_5_0",    F3_DIVU, 32'd5,         32'd0);
    run_op("remu_5_0",    F3_REMU, 32'd5,         32'd0);
    run_op("div_ovf",     F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",     F3_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_min_2",   F3_DIV,  32'h8000_0000, 32'd2);

    // Flush mid-operation
    prev    = bus_if.result;
    seen_rv = 1'b0;
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.funct3    = F3_DIV;
    bus_if.operand_a = 32'd100;
    bus_if.operand_b = 32'd3;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus_if.result_valid) seen_rv = 1'b1;
    end
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",   32'(bus_if.busy), 32'd0);
    chk("flush_stall",  32'(bus_if.stall), 32'd0);
    chk("flush_result", bus_if.result, prev);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus_if.result_valid) seen_rv = 1'b1;
    end
    chk("flush_no_rv", 32'(seen_rv), 32'd0);
    run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3);

    // Reset mid-operation
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.funct3    = F3_DIV;
    bus_if.operand_a = 32'd1000;
    bus_if.operand_b = 32'd7;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",   32'(bus_if.busy), 32'd0);
    chk("midrst_result", bus_if.result, 32'd0);
    chk("midrst_rv",     32'(bus_if.result_valid), 32'd0);
    chk("midrst_stall",  32'(bus_if.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // START and FLUSH together
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.flush     = 1'b1;
    bus_if.funct3    = F3_DIVU;
    bus_if.operand_a = 32'd50;
    bus_if.operand_b = 32'd5;
    #1;
    chk("sf_stall", 32'(bus_if.stall), 32'd0);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("sf_busy", 32'(bus_if.busy), 32'd0);
    chk("sf_rv",   32'(bus_if.result_valid), 32'd0);

    // Randomised ops
    for (int i = 0; i < 60; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 255);
        2:       a = 32'hFFFF_FFFF - $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("rand", f3, a, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
